// File: rtl/motor_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | motor_timer: BCD countdown that drives one motor for a set time.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module motor_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [3:0] TValue0,
  input  logic [3:0] TValue1,
  input  logic [3:0] TValue2,
  input  logic [5:0] Motor,
  output logic [5:0] MotorOut,
  output logic [3:0] Remain0,
  output logic [3:0] Remain1,
  output logic [3:0] Remain2,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       motor_prev_q;
  logic [5:0]       motor_out_q, motor_out_d;
  logic [11:0]      remain_q, remain_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             err_q, err_d;

  logic [11:0] w_tvalue;
  logic        w_new_cmd;
  logic        w_cmd_ok;
  logic        w_accept;
  logic        w_reject;
  logic        w_load;

  // Three-digit BCD decrement; the caller guarantees a nonzero operand.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        d2 = d2 - 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  assign w_tvalue  = {TValue2, TValue1, TValue0};
  assign w_new_cmd = (Motor != motor_prev_q) && (Motor != 6'd0);
  assign w_cmd_ok  = ((Motor & 6'(Motor - 6'd1)) == 6'd0)
                   && (TValue0 <= 4'd9) && (TValue1 <= 4'd9) && (TValue2 <= 4'd9);
  assign w_accept  = w_new_cmd && w_cmd_ok;
  assign w_reject  = w_new_cmd && !w_cmd_ok;

  always_comb begin
    state_d     = state_q;
    motor_out_d = motor_out_q;
    remain_d    = remain_q;
    pre_d       = pre_q;
    err_d       = err_q;
    w_load      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (w_reject)      err_d  = 1'b1;
        else if (w_accept) w_load = 1'b1;
      end
      S_RUN: begin
        if (Motor == 6'd0) begin
          // Selection withdrawn: abort silently, no completion pulse.
          state_d     = S_IDLE;
          motor_out_d = 6'd0;
          remain_d    = 12'd0;
        end else if (w_accept) begin
          w_load = 1'b1;
        end else begin
          if (w_reject) err_d = 1'b1;
          if (pre_q != '0) begin
            pre_d = pre_q - 1'b1;
          end else begin
            pre_d = PRE_RELOAD;
            if (remain_q == 12'h001) begin
              remain_d    = 12'd0;
              motor_out_d = 6'd0;
              state_d     = S_DONE;
            end else if (remain_q != 12'd0) begin
              remain_d = bcd_dec(remain_q);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_load) begin
      err_d    = 1'b0;
      remain_d = w_tvalue;
      pre_d    = PRE_RELOAD;
      if (w_tvalue == 12'd0) begin
        state_d     = S_DONE;
        motor_out_d = 6'd0;
      end else begin
        state_d     = S_RUN;
        motor_out_d = Motor;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      motor_prev_q <= 6'd0;
      motor_out_q  <= 6'd0;
      remain_q     <= 12'd0;
      pre_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      motor_prev_q <= Motor;
      motor_out_q  <= motor_out_d;
      remain_q     <= remain_d;
      pre_q        <= pre_d;
      err_q        <= err_d;
    end
  end

  assign MotorOut = motor_out_q;
  assign Remain0  = remain_q[3:0];
  assign Remain1  = remain_q[7:4];
  assign Remain2  = remain_q[11:8];
  assign Busy     = (state_q == S_RUN);
  assign Done     = (state_q == S_DONE);
  assign Err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_motor_timer: scoreboard bench for motor_timer, TICK_DIV = 4.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_motor_timer;

  localparam int TICK_DIV = 4;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b0;
  logic [3:0] TValue0 = 4'd0, TValue1 = 4'd0, TValue2 = 4'd0;
  logic [5:0] Motor = 6'd0;
  logic [5:0] MotorOut;
  logic [3:0] Remain0, Remain1, Remain2;
  logic       Busy, Done, Err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [5:0]  mo;
    logic [11:0] rem;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb[$];

  motor_timer #(.TICK_DIV(TICK_DIV)) u_dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .TValue0 (TValue0),
    .TValue1 (TValue1),
    .TValue2 (TValue2),
    .Motor   (Motor),
    .MotorOut(MotorOut),
    .Remain0 (Remain0),
    .Remain1 (Remain1),
    .Remain2 (Remain2),
    .Busy    (Busy),
    .Done    (Done),
    .Err     (Err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [5:0] mo, input logic [11:0] rem,
                      input logic busy, input logic done, input logic err);
    exp_t e;
    e.tag = tag; e.mo = mo; e.rem = rem; e.busy = busy; e.done = done; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".motor"},  32'(MotorOut), 32'(e.mo));
      chk({e.tag, ".remain"}, 32'({Remain2, Remain1, Remain0}), 32'(e.rem));
      chk({e.tag, ".busy"},   32'(Busy), 32'(e.busy));
      chk({e.tag, ".done"},   32'(Done), 32'(e.done));
      chk({e.tag, ".err"},    32'(Err),  32'(e.err));
    end
  endtask

  // Advance n rising edges, leaving time just past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic [5:0] m, input logic [3:0] t2, input logic [3:0] t1,
                       input logic [3:0] t0);
    Motor = m; TValue2 = t2; TValue1 = t1; TValue0 = t0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    push("reset", 6'd0, 12'h000, 1'b0, 1'b0, 1'b0); drain();
    rst = 1'b1;
    step(1);

    // Basic two-tick run
    drive(6'b010000, 4'd0, 4'd0, 4'd2);
    step(1); push("run2.start", 6'b010000, 12'h002, 1'b1, 1'b0, 1'b0); drain();
    step(3); push("run2.pre",   6'b010000, 12'h002, 1'b1, 1'b0, 1'b0); drain();
    step(1); push("run2.tick1", 6'b010000, 12'h001, 1'b1, 1'b0, 1'b0); drain();
    step(4); push("run2.done",  6'd0,      12'h000, 1'b0, 1'b1, 1'b0); drain();
    step(1); push("run2.idle",  6'd0,      12'h000, 1'b0, 1'b0, 1'b0); drain();
    step(10); push("run2.hold", 6'd0,      12'h000, 1'b0, 1'b0, 1'b0); drain();
    drive(6'd0, 4'd0, 4'd0, 4'd0); step(1);

    // BCD borrow across two digits
    drive(6'b000001, 4'd1, 4'd0, 4'd0);
    step(1);   push("bor.start", 6'b000001, 12'h100, 1'b1, 1'b0, 1'b0); drain();
    step(4);   push("bor.099",   6'b000001, 12'h099, 1'b1, 1'b0, 1'b0); drain();
    step(40);  push("bor.089",   6'b000001, 12'h089, 1'b1, 1'b0, 1'b0); drain();
    step(356); push("bor.done",  6'd0,      12'h000, 1'b0, 1'b1, 1'b0); drain();
    step(1);
    drive(6'd0, 4'd0, 4'd0, 4'd0); step(1);

    // Zero time goes straight to completion
    drive(6'b100000, 4'd0, 4'd0, 4'd0);
    step(1); push("zero.done", 6'd0, 12'h000, 1'b0, 1'b1, 1'b0); drain();
    step(1); push("zero.idle", 6'd0, 12'h000, 1'b0, 1'b0, 1'b0); drain();
    drive(6'd0, 4'd0, 4'd0, 4'd0); step(1);

    // Rejections and recovery
    drive(6'b011000, 4'd0, 4'd0, 4'd5);
    step(1); push("rej.twohot", 6'd0, 12'h000, 1'b0, 1'b0, 1'b1); drain();
    drive(6'd0, 4'd0, 4'd0, 4'd0); step(1);
    push("rej.sticky", 6'd0, 12'h000, 1'b0, 1'b0, 1'b1); drain();
    drive(6'b000010, 4'd0, 4'd0, 4'hA);
    step(1); push("rej.digit", 6'd0, 12'h000, 1'b0, 1'b0, 1'b1); drain();
    drive(6'b000100, 4'd0, 4'd0, 4'd5);
    step(1); push("rej.recover", 6'b000100, 12'h005, 1'b1, 1'b0, 1'b0); drain();
    drive(6'b110000, 4'd0, 4'd0, 4'd5);
    step(1); push("rej.inrun", 6'b000100, 12'h005, 1'b1, 1'b0, 1'b1); drain();

    // Abort mid-run
    drive(6'd0, 4'd0, 4'd0, 4'd5);
    step(1); push("abort", 6'd0, 12'h000, 1'b0, 1'b0, 1'b1); drain();
    step(3); push("abort.nodone", 6'd0, 12'h000, 1'b0, 1'b0, 1'b1); drain();

    // Restart mid-run, then a new command in the DONE cycle
    drive(6'b000100, 4'd0, 4'd0, 4'd5);
    step(1); push("rst5.start", 6'b000100, 12'h005, 1'b1, 1'b0, 1'b0); drain();
    drive(6'b001000, 4'd0, 4'd0, 4'd3);
    step(1);  push("restart",      6'b001000, 12'h003, 1'b1, 1'b0, 1'b0); drain();
    step(12); push("restart.done", 6'd0,      12'h000, 1'b0, 1'b1, 1'b0); drain();
    drive(6'b000010, 4'd0, 4'd0, 4'd1);
    step(1); push("donecmd", 6'b000010, 12'h001, 1'b1, 1'b0, 1'b0); drain();

    // Asynchronous reset mid-run, then re-trigger from the held selection
    step(1);
    #2 rst = 1'b0;
    #1 push("async.rst", 6'd0, 12'h000, 1'b0, 1'b0, 1'b0); drain();
    #1 rst = 1'b1;
    step(1); push("post.rst", 6'b000010, 12'h001, 1'b1, 1'b0, 1'b0); drain();
    drive(6'b000010, 4'd0, 4'd0, 4'd7);
    step(3); push("tv.ignored", 6'b000010, 12'h001, 1'b1, 1'b0, 1'b0); drain();
    step(1); push("post.done",  6'd0,      12'h000, 1'b0, 1'b1, 1'b0); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
